// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Imported by the fetch top and its instruction buffer.
package fetch_unit_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] PC_STEP   = 32'd4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_FLUSH = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/fetch_unit_fifo.sv
// Small instruction buffer between fetch and decode.
// Flush wins over push and pop; pointers wrap modulo DEPTH.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues single-outstanding
// word requests and buffers returned instructions for decode.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    output logic        o_instr_valid,
    output logic [31:0] o_Instr,
    output logic [31:0] o_pc,
    input  logic        i_dec_ready,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_misalign
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e state_q;
    fetch_state_e state_d;
    logic [31:0]  pc_q;
    logic [31:0]  pc_d;
    logic [31:0]  inflight_q;
    logic [31:0]  inflight_d;
    logic [31:0]  last_pc_q;
    logic         misalign_q;

    logic          grant;
    logic          push;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    fetch_entry_t  wr_entry;
    fetch_entry_t  head;

    // S_IDLE means nothing in flight, so a free slot is guaranteed at rvalid
    assign o_imem_req  = i_rst_n & (state_q == S_IDLE) & ~i_redirect & ~fifo_full;
    assign o_imem_addr = pc_q;
    assign grant       = o_imem_req & i_imem_gnt;

    assign push = (state_q == S_WAIT) & i_imem_rvalid & ~i_redirect;
    assign pop  = i_dec_ready & ~fifo_empty & ~i_redirect;

    assign wr_entry.pc    = inflight_q;
    assign wr_entry.instr = i_imem_rdata;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .push  (push),
        .pop   (pop),
        .flush (i_redirect),
        .wdata (wr_entry),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        inflight_d = inflight_q;
        if (i_redirect) begin
            pc_d = {i_redirect_pc[31:2], 2'b00};
            unique case (state_q)
                S_WAIT, S_FLUSH: state_d = i_imem_rvalid ? S_IDLE : S_FLUSH;
                default:         state_d = S_IDLE;
            endcase
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (grant) begin
                        state_d    = S_WAIT;
                        inflight_d = pc_q;
                        pc_d       = pc_inc(pc_q);
                    end
                end
                S_WAIT: begin
                    if (i_imem_rvalid) state_d = S_IDLE;
                end
                S_FLUSH: begin
                    if (i_imem_rvalid) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            inflight_q <= '0;
            last_pc_q  <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            misalign_q <= i_redirect & (|i_redirect_pc[1:0]);
            if (!fifo_empty) begin
                last_pc_q <= head.pc;
            end
        end
    end

    assign o_instr_valid = ~fifo_empty;
    assign o_Instr       = fifo_empty ? NOP_INSTR : head.instr;
    assign o_pc          = fifo_empty ? last_pc_q : head.pc;
    assign o_misalign    = misalign_q;

    logic unused_count;
    assign unused_count = ^fifo_count;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a single-outstanding memory responder.
// Data returned for address A is A ^ 32'hA5A5_0000.
module tb_fetch_unit;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_gnt;
    logic        i_imem_rvalid;
    logic [31:0] i_imem_rdata;
    logic        o_instr_valid;
    logic [31:0] o_Instr;
    logic [31:0] o_pc;
    logic        i_dec_ready;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        o_misalign;

    int nvec  = 0;
    int nfail = 0;

    int          resp_delay = 1;
    logic        pend       = 1'b0;
    int          left       = 0;
    logic [31:0] paddr      = '0;
    logic        granted;
    logic [31:0] gaddr;

    fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .o_imem_req    (o_imem_req),
        .o_imem_addr   (o_imem_addr),
        .i_imem_gnt    (i_imem_gnt),
        .i_imem_rvalid (i_imem_rvalid),
        .i_imem_rdata  (i_imem_rdata),
        .o_instr_valid (o_instr_valid),
        .o_Instr       (o_Instr),
        .o_pc          (o_pc),
        .i_dec_ready   (i_dec_ready),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .o_misalign    (o_misalign)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic settle();
        #1;
    endtask

    // One clock: sample the handshake before the edge, drive the
    // memory response for the following cycle after it.
    task automatic tick();
        #1;
        granted = o_imem_req && i_imem_gnt;
        gaddr   = o_imem_addr;
        @(posedge i_clk);
        #1;
        i_imem_rvalid = 1'b0;
        i_imem_rdata  = 32'hDEAD_BEEF;
        if (!i_rst_n) begin
            pend = 1'b0;
        end else begin
            if (granted) begin
                pend  = 1'b1;
                left  = resp_delay;
                paddr = gaddr;
            end
            if (pend) begin
                left--;
                if (left == 0) begin
                    i_imem_rvalid = 1'b1;
                    i_imem_rdata  = paddr ^ 32'hA5A5_0000;
                    pend          = 1'b0;
                end
            end
        end
    endtask

    initial begin
        i_rst_n       = 1'b0;
        i_imem_gnt    = 1'b1;
        i_imem_rvalid = 1'b0;
        i_imem_rdata  = '0;
        i_dec_ready   = 1'b1;
        i_redirect    = 1'b0;
        i_redirect_pc = '0;
        tick();
        tick();
        chk("rst_req", 32'(o_imem_req), 32'd0);
        chk("rst_valid", 32'(o_instr_valid), 32'd0);
        chk("rst_instr", o_Instr, 32'h0000_0013);
        chk("rst_pc", o_pc, 32'h0);
        chk("rst_misalign", 32'(o_misalign), 32'd0);

        i_rst_n = 1'b1;
        settle();
        chk("rel_req", 32'(o_imem_req), 32'd1);
        chk("rel_addr", o_imem_addr, 32'h0);
        tick();
        chk("first_lat_valid", 32'(o_instr_valid), 32'd0);
        tick();
        for (int k = 0; k < 3; k++) begin
            chk("seq_valid", 32'(o_instr_valid), 32'd1);
            chk("seq_pc", o_pc, 32'(4 * k));
            chk("seq_instr", o_Instr, 32'(4 * k) ^ 32'hA5A5_0000);
            tick();
            chk("seq_gap_valid", 32'(o_instr_valid), 32'd0);
            chk("seq_gap_instr", o_Instr, 32'h0000_0013);
            chk("seq_gap_pc", o_pc, 32'(4 * k));
            tick();
        end

        i_dec_ready = 1'b0;
        settle();
        chk("stall_pc0", o_pc, 32'h0000_000C);
        chk("stall_req0", 32'(o_imem_req), 32'd1);
        chk("stall_addr0", o_imem_addr, 32'h0000_0010);
        tick();
        tick();
        chk("full_req", 32'(o_imem_req), 32'd0);
        chk("full_valid", 32'(o_instr_valid), 32'd1);
        chk("full_pc", o_pc, 32'h0000_000C);
        chk("full_instr", o_Instr, 32'hA5A5_000C);
        tick();
        chk("full_req2", 32'(o_imem_req), 32'd0);
        chk("full_pc2", o_pc, 32'h0000_000C);
        i_dec_ready = 1'b1;
        tick();
        chk("drain_pc", o_pc, 32'h0000_0010);
        chk("drain_instr", o_Instr, 32'hA5A5_0010);
        chk("resume_req", 32'(o_imem_req), 32'd1);
        chk("resume_addr", o_imem_addr, 32'h0000_0014);
        tick();
        chk("drain_empty", 32'(o_instr_valid), 32'd0);
        resp_delay = 3;
        tick();
        chk("pre_redir_pc", o_pc, 32'h0000_0014);
        chk("pre_redir_addr", o_imem_addr, 32'h0000_0018);

        tick();
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h0000_0100;
        settle();
        chk("redir_wait_req", 32'(o_imem_req), 32'd0);
        tick();
        i_redirect = 1'b0;
        settle();
        chk("flush_req", 32'(o_imem_req), 32'd0);
        tick();
        chk("flush_drop_valid", 32'(o_instr_valid), 32'd0);
        resp_delay = 1;
        tick();
        chk("flush_next_req", 32'(o_imem_req), 32'd1);
        chk("flush_next_addr", o_imem_addr, 32'h0000_0100);
        chk("flush_still_empty", 32'(o_instr_valid), 32'd0);
        tick();
        tick();
        chk("redir_first_valid", 32'(o_instr_valid), 32'd1);
        chk("redir_first_pc", o_pc, 32'h0000_0100);
        chk("redir_first_instr", o_Instr, 32'hA5A5_0100);

        i_dec_ready = 1'b0;
        tick();
        chk("hold_head_pc", o_pc, 32'h0000_0100);
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h0000_0200;
        i_dec_ready   = 1'b1;
        tick();
        i_redirect = 1'b0;
        settle();
        chk("redir_rv_valid", 32'(o_instr_valid), 32'd0);
        chk("redir_rv_instr", o_Instr, 32'h0000_0013);
        chk("redir_rv_pc", o_pc, 32'h0000_0100);
        chk("redir_rv_req", 32'(o_imem_req), 32'd1);
        chk("redir_rv_addr", o_imem_addr, 32'h0000_0200);
        chk("redir_rv_mis", 32'(o_misalign), 32'd0);
        tick();
        tick();
        chk("redir200_pc", o_pc, 32'h0000_0200);
        chk("redir200_instr", o_Instr, 32'hA5A5_0200);

        tick();
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h0000_0106;
        tick();
        i_redirect = 1'b0;
        settle();
        chk("misalign_pulse", 32'(o_misalign), 32'd1);
        chk("misalign_req", 32'(o_imem_req), 32'd1);
        chk("misalign_addr", o_imem_addr, 32'h0000_0104);
        tick();
        chk("misalign_drop", 32'(o_misalign), 32'd0);
        tick();
        chk("misalign_pc", o_pc, 32'h0000_0104);
        chk("misalign_instr", o_Instr, 32'hA5A5_0104);

        tick();
        i_redirect    = 1'b1;
        i_redirect_pc = 32'hFFFF_FFFC;
        tick();
        i_redirect = 1'b0;
        settle();
        chk("top_addr", o_imem_addr, 32'hFFFF_FFFC);
        tick();
        tick();
        chk("top_pc", o_pc, 32'hFFFF_FFFC);
        chk("top_instr", o_Instr, 32'h5A5A_FFFC);
        chk("wrap_req", 32'(o_imem_req), 32'd1);
        chk("wrap_addr", o_imem_addr, 32'h0000_0000);

        resp_delay = 3;
        tick();
        chk("wait_empty", 32'(o_instr_valid), 32'd0);
        i_rst_n = 1'b0;
        tick();
        chk("mid_rst_req", 32'(o_imem_req), 32'd0);
        chk("mid_rst_valid", 32'(o_instr_valid), 32'd0);
        chk("mid_rst_instr", o_Instr, 32'h0000_0013);
        chk("mid_rst_pc", o_pc, 32'h0);
        chk("mid_rst_mis", 32'(o_misalign), 32'd0);
        i_rst_n    = 1'b1;
        resp_delay = 1;
        settle();
        chk("post_rst_req", 32'(o_imem_req), 32'd1);
        chk("post_rst_addr", o_imem_addr, 32'h0);
        tick();
        tick();
        chk("post_rst_valid", 32'(o_instr_valid), 32'd1);
        chk("post_rst_pc", o_pc, 32'h0);
        chk("post_rst_instr", o_Instr, 32'hA5A5_0000);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage; produces the 32-bit instruction word consumed by the decoder/control unit.
- Takes redirects back from branch/jal/jalr resolution in execute.
- Owns the fetch PC and issues word requests to instruction memory over a req/gnt/rvalid protocol, with at most 1 request outstanding.
- Buffers returned words in a small FIFO and presents them to decode with a valid/ready handshake.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset; must be word aligned.
- FIFO_DEPTH, 2, instruction buffer entries; power of two, 2..8.

Ports:
- i_clk  input  1  clock; all state updates on rising edge
- i_rst_n  input  1  reset, synchronous, active-low
- o_imem_req  output  1  fetch request valid
- o_imem_addr  output  32  word-aligned fetch address
- i_imem_gnt  input  1  request accepted this cycle (only meaningful when o_imem_req=1)
- i_imem_rvalid  input  1  read data valid; at least 1 cycle after grant, in order
- i_imem_rdata  input  32  instruction word
- o_instr_valid  output  1  FIFO head valid
- o_Instr  output  32  FIFO head instruction
- o_pc  output  32  PC of FIFO head
- i_dec_ready  input  1  decode accepts head this cycle
- i_redirect  input  1  flush and redirect (taken branch, jal, jalr)
- i_redirect_pc  input  32  redirect target
- o_misalign  output  1  1-cycle pulse, registered: redirect target had [1:0]!=0

Behaviour:
- Reset (i_rst_n=0 at edge): fetch PC=RESET_PC, state=S_IDLE, FIFO empty.
  - Reset values: o_imem_req=0, o_instr_valid=0, o_Instr=32'h0000_0013 (NOP), o_pc=0, o_misalign=0.
  - Reset mid-transaction abandons any outstanding request; a late rvalid after reset is ignored only if it arrives in S_IDLE.
  - Memory must be reset together with this block.
- States:
  - S_IDLE: no outstanding request.
  - S_WAIT: 1 request outstanding; response is kept.
  - S_FLUSH: 1 request outstanding; response is discarded.
- Request rule:
  - o_imem_req=1 iff state=S_IDLE, i_redirect=0, and fifo_count < FIFO_DEPTH.
  - o_imem_addr = fetch PC (combinational from the PC register).
- Grant (req & gnt): state S_IDLE->S_WAIT; latch the PC as in-flight PC; fetch PC += 4, wrapping 32'hFFFF_FFFC -> 0.
- S_WAIT, rvalid & !redirect: push {in-flight PC, rdata}; ->S_IDLE.
  - Push and decode pop may occur in the same cycle; count is unchanged.
- Redirect (highest priority, any state):
  - Fetch PC <= {i_redirect_pc[31:2], 2'b00}; FIFO cleared; any pop in the same cycle is ignored.
  - S_WAIT without rvalid -> S_FLUSH.
  - S_WAIT with rvalid -> S_IDLE; data dropped.
  - S_FLUSH with rvalid -> S_IDLE.
  - S_FLUSH without rvalid -> stays S_FLUSH; PC updated.
  - S_IDLE -> S_IDLE.
  - o_misalign=1 next cycle iff i_redirect_pc[1:0]!=0.
- S_FLUSH, rvalid: discard, ->S_IDLE; the next request is issued in the same cycle as the transition edge +1.
- Output:
  - o_instr_valid = count!=0; o_Instr/o_pc show the head entry.
  - Head is stable while o_instr_valid & !i_dec_ready (unless redirect).
  - When the FIFO is empty, o_Instr shows NOP and o_pc holds its last value.
- Latency:
  - Reset release (first cycle with i_rst_n=1) -> req asserted that cycle.
  - gnt at cycle N, rvalid at N+1 -> o_instr_valid at N+2.
  - Steady-state throughput: 1 instruction per 2 cycles with single outstanding.
- Full: with count==FIFO_DEPTH, no request. A response landing when full is impossible because the request rule counts the in-flight slot: request only if count + (state!=S_IDLE) < FIFO_DEPTH. S_IDLE implies 0 in flight.
- Withdrawal: req may drop without gnt only on redirect or on reset.

Decomposition:
- Add to parameters.vh:
  - NOP_INSTR=32'h0000_0013
  - state encodings S_IDLE=2'd0, S_WAIT=2'd1, S_FLUSH=2'd2
  - PC_STEP=4
- Sub-module fetch_fifo:
  - Parameterised depth and width (64: pc+instr).
  - Ports: push, pop, flush, full, empty, count.
  - Pointer wrap modulo depth.
  - flush has priority over push/pop.

Test Plan:
- Reset release, gnt=1 always, rvalid 1 cycle after gnt, rdata=addr^32'hA5A5_0000, dec_ready=1 -> addresses 0,4,8,...; o_pc/o_Instr match in order; first o_instr_valid 2 cycles after first grant.
- dec_ready=0 with FIFO_DEPTH=2 -> exactly 2 entries buffered; req low while full; head 0/instr stable; release ready -> 0 then 4 popped, fetch resumes at 8.
- Redirect to 32'h100 while in S_WAIT, rvalid 2 cycles later with data D -> D never appears; next request addr=32'h100; first valid o_pc=32'h100.
- Redirect to 32'h200 in the same cycle as rvalid and a decode pop -> FIFO empty next cycle, response dropped, req addr=32'h200 the following cycle.
- Redirect to 32'h0000_0106 -> o_misalign pulses 1 cycle; fetch addr=32'h104.
- PC=32'hFFFF_FFFC granted -> next addr 32'h0; reset asserted in S_WAIT -> o_instr_valid=0, o_Instr=NOP, req addr=RESET_PC after release.
